// File: rtl/ifmap_cfg_pkg.sv
// Shared configuration helpers for the nested ifmap counter: width helper,
// default bound, and the per-level slice macro for packed cfg/count buses.
`define IFMAP_CFG_SLICE(vec, i, w) vec[(i)*(w) +: (w)]

package ifmap_cfg_pkg;

  localparam int DEFAULT_MAX_BOUND = 255;

  // Minimum one bit so a degenerate MAX_BOUND of 0 still yields a legal vector.
  function automatic int ceil_log2(input int value);
    int bits;
    bits = 0;
    while ((32'(1) << bits) < value) bits++;
    return (bits == 0) ? 1 : bits;
  endfunction

endpackage

// File: rtl/ifmap_counter_level.sv
// One odometer digit: counts 0..bound, wraps when carried into at its bound,
// remembers the value before the last accepted step.
module ifmap_counter_level #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             step,
  input  logic [WIDTH-1:0] bound,
  input  logic             carry_in,
  input  logic             load_zero,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] prev_count,
  output logic             at_max,
  output logic             wrap
);

  assign at_max = (count == bound);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count      <= '0;
      prev_count <= '0;
      wrap       <= 1'b0;
    end else if (load_zero) begin
      count      <= '0;
      prev_count <= '0;
      wrap       <= 1'b0;
    end else if (step) begin
      prev_count <= count;
      if (carry_in && at_max) begin
        count <= '0;
        wrap  <= 1'b1;
      end else if (carry_in) begin
        count <= count + 1'b1;
        wrap  <= 1'b0;
      end else begin
        wrap  <= 1'b0;
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: rtl/ifmap_nested_counter.sv
// NUM_LEVELS-deep nested loop index generator for the PE-array feeder.
// Level 0 is innermost; bounds latch on an accepted start.
module ifmap_nested_counter
  import ifmap_cfg_pkg::*;
#(
  parameter int NUM_LEVELS = 3,
  parameter int MAX_BOUND  = DEFAULT_MAX_BOUND,
  parameter int WIDTH      = ceil_log2(MAX_BOUND + 1),
  parameter bit WRAP_MODE  = 1'b0
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        start,
  input  logic [NUM_LEVELS*WIDTH-1:0] cfg_max,
  input  logic                        en,
  input  logic                        clear,
  output logic                        busy,
  output logic                        done,
  output logic [NUM_LEVELS-1:0]       at_max,
  output logic [NUM_LEVELS-1:0]       level_wrap,
  output logic [NUM_LEVELS*WIDTH-1:0] count,
  output logic [NUM_LEVELS*WIDTH-1:0] prev_count
);

  logic [NUM_LEVELS*WIDTH-1:0] bounds;
  logic [NUM_LEVELS-1:0]       carry;
  logic                        start_acc;
  logic                        step;
  logic                        load_zero;
  logic                        final_idx;

  assign start_acc = start && !busy && !clear;
  assign step      = en && busy && !clear && !start_acc;
  assign load_zero = clear || start_acc;
  assign final_idx = &at_max;

  // Carry into level i is the AND-prefix of at_max over all inner levels.
  always_comb begin
    logic acc;
    carry = '0;
    acc   = 1'b1;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      carry[i] = acc;
      acc      = acc & at_max[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      bounds <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clear) begin
        busy <= 1'b0;
      end else if (start_acc) begin
        bounds <= cfg_max;
        busy   <= 1'b1;
      end else if (step && final_idx) begin
        done <= 1'b1;
        if (!WRAP_MODE) busy <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < NUM_LEVELS; i++) begin : g_level
    ifmap_counter_level #(.WIDTH(WIDTH)) u_level (
      .clk        (clk),
      .rstn       (rstn),
      .step       (step),
      .bound      (`IFMAP_CFG_SLICE(bounds, i, WIDTH)),
      .carry_in   (carry[i]),
      .load_zero  (load_zero),
      .count      (`IFMAP_CFG_SLICE(count, i, WIDTH)),
      .prev_count (`IFMAP_CFG_SLICE(prev_count, i, WIDTH)),
      .at_max     (at_max[i]),
      .wrap       (level_wrap[i])
    );
  end

endmodule

// File: tb/tb_ifmap_nested_counter.sv
// Directed bench: a stop-mode and a wrap-mode counter share one stimulus stream.
module tb_ifmap_nested_counter;

  logic        clk;
  logic        rstn;
  logic        start;
  logic [23:0] cfg_max;
  logic        en;
  logic        clear;

  logic        busy0, done0, busy1, done1;
  logic [2:0]  at_max0, level_wrap0, at_max1, level_wrap1;
  logic [23:0] count0, prev_count0, count1, prev_count1;

  int n_checks;
  int n_fail;

  ifmap_nested_counter #(.NUM_LEVELS(3), .MAX_BOUND(255), .WRAP_MODE(1'b0)) dut_stop (
    .clk(clk), .rstn(rstn), .start(start), .cfg_max(cfg_max), .en(en), .clear(clear),
    .busy(busy0), .done(done0), .at_max(at_max0), .level_wrap(level_wrap0),
    .count(count0), .prev_count(prev_count0)
  );

  ifmap_nested_counter #(.NUM_LEVELS(3), .MAX_BOUND(255), .WRAP_MODE(1'b1)) dut_wrap (
    .clk(clk), .rstn(rstn), .start(start), .cfg_max(cfg_max), .en(en), .clear(clear),
    .busy(busy1), .done(done1), .at_max(at_max1), .level_wrap(level_wrap1),
    .count(count1), .prev_count(prev_count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected odometer position after k steps for bounds b0 (inner) .. b2 (outer).
  function automatic logic [23:0] idx(input int k, input int b0, input int b1, input int b2);
    int l0, l1, l2;
    l0 = k % (b0 + 1);
    l1 = (k / (b0 + 1)) % (b1 + 1);
    l2 = (k / ((b0 + 1) * (b1 + 1))) % (b2 + 1);
    return {8'(l2), 8'(l1), 8'(l0)};
  endfunction

  task automatic clear_and_start(input logic [23:0] cfg);
    clear = 1'b1;
    tick();
    clear   = 1'b0;
    start   = 1'b1;
    cfg_max = cfg;
    tick();
    start   = 1'b0;
    cfg_max = 24'h0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rstn     = 1'b0;
    start    = 1'b0;
    cfg_max  = '0;
    en       = 1'b0;
    clear    = 1'b0;
    tick();
    tick();
    rstn = 1'b1;

    // Reset state: bounds 0 and counts 0 make every level at_max.
    check_eq("rst_count", count0, 24'h0);
    check_eq("rst_prev", prev_count0, 24'h0);
    check_eq("rst_busy", busy0, 1'b0);
    check_eq("rst_done", done0, 1'b0);
    check_eq("rst_wrap", level_wrap0, 3'b000);
    check_eq("rst_at_max", at_max0, 3'b111);

    // Basic walk with bounds {1,2,3}; wrap-mode instance continues to 48 steps.
    clear_and_start({8'd1, 8'd2, 8'd3});
    check_eq("start_busy", busy0, 1'b1);
    check_eq("start_count", count0, 24'h0);
    en = 1'b1;
    for (int s = 1; s <= 48; s++) begin
      tick();
      if (s <= 24) begin
        check_eq($sformatf("basic_count_%0d", s), count0, idx(s, 3, 2, 1));
        check_eq($sformatf("basic_prev_%0d", s), prev_count0, idx(s - 1, 3, 2, 1));
        check_eq($sformatf("basic_done_%0d", s), done0, (s == 24));
        check_eq($sformatf("basic_busy_%0d", s), busy0, (s < 24));
      end else begin
        check_eq($sformatf("idle_count_%0d", s), count0, 24'h0);
        check_eq($sformatf("idle_prev_%0d", s), prev_count0, {8'd1, 8'd2, 8'd3});
        check_eq($sformatf("idle_done_%0d", s), done0, 1'b0);
        check_eq($sformatf("idle_lwrap_%0d", s), level_wrap0, 3'b000);
      end
      check_eq($sformatf("wrap_count_%0d", s), count1, idx(s, 3, 2, 1));
      check_eq($sformatf("wrap_done_%0d", s), done1, (s == 24 || s == 48));
      check_eq($sformatf("wrap_busy_%0d", s), busy1, 1'b1);
      check_eq($sformatf("wrap_lwrap_%0d", s), level_wrap1,
               {(s % 24 == 0), (s % 12 == 0), (s % 4 == 0)});
    end
    en = 1'b0;

    // Zero bound on the middle level passes carry straight through.
    clear_and_start({8'd2, 8'd0, 8'd1});
    en = 1'b1;
    for (int s = 1; s <= 6; s++) begin
      tick();
      check_eq($sformatf("zero_count_%0d", s), count0, idx(s, 1, 0, 2));
      check_eq($sformatf("zero_at_max1_%0d", s), at_max0[1], 1'b1);
      check_eq($sformatf("zero_done_%0d", s), done0, (s == 6));
    end
    check_eq("zero_busy_end", busy0, 1'b0);
    en = 1'b0;

    // Clear together with en at step 5 wins over the step.
    clear_and_start({8'd1, 8'd2, 8'd3});
    en = 1'b1;
    for (int s = 1; s <= 4; s++) tick();
    check_eq("clr_pre_count", count0, idx(4, 3, 2, 1));
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_eq("clr_count", count0, 24'h0);
    check_eq("clr_prev", prev_count0, 24'h0);
    check_eq("clr_busy", busy0, 1'b0);
    for (int s = 0; s < 3; s++) begin
      tick();
      check_eq($sformatf("clr_hold_count_%0d", s), count0, 24'h0);
      check_eq($sformatf("clr_hold_prev_%0d", s), prev_count0, 24'h0);
      check_eq($sformatf("clr_hold_busy_%0d", s), busy0, 1'b0);
      check_eq($sformatf("clr_hold_done_%0d", s), done0, 1'b0);
      check_eq($sformatf("clr_hold_lwrap_%0d", s), level_wrap0, 3'b000);
      check_eq($sformatf("clr_hold_at_max_%0d", s), at_max0, 3'b000);
    end
    en = 1'b0;

    // Start while busy is ignored and the step on that cycle still counts.
    clear_and_start({8'd1, 8'd2, 8'd3});
    en = 1'b1;
    for (int s = 1; s <= 24; s++) begin
      if (s == 3) begin
        start   = 1'b1;
        cfg_max = {8'd9, 8'd9, 8'd9};
      end
      tick();
      start   = 1'b0;
      cfg_max = 24'h0;
      check_eq($sformatf("sib_count_%0d", s), count0, idx(s, 3, 2, 1));
      check_eq($sformatf("sib_done_%0d", s), done0, (s == 24));
    end
    check_eq("sib_busy_end", busy0, 1'b0);

    // Reset mid-sequence with en held high.
    clear_and_start({8'd1, 8'd2, 8'd3});
    for (int s = 1; s <= 5; s++) tick();
    check_eq("rstmid_pre_count", count0, idx(5, 3, 2, 1));
    rstn = 1'b0;
    tick();
    check_eq("rstmid_count", count0, 24'h0);
    check_eq("rstmid_prev", prev_count0, 24'h0);
    check_eq("rstmid_busy", busy0, 1'b0);
    check_eq("rstmid_done", done0, 1'b0);
    check_eq("rstmid_lwrap", level_wrap0, 3'b000);
    check_eq("rstmid_at_max", at_max0, 3'b111);
    check_eq("rstmid_wrap_busy", busy1, 1'b0);
    rstn = 1'b1;
    en   = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
